// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package muldiv_pkg;

    localparam int         MULDIV_N   = 64;
    localparam int         MULDIV_LAT = MULDIV_N + 1;
    localparam logic [4:0] XZR_ADDR   = 5'd31;

    typedef enum logic [1:0] {
        OP_MUL   = 2'b00,
        OP_UMULH = 2'b01,
        OP_UDIV  = 2'b10,
        OP_SDIV  = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    function automatic logic is_div(input op_t o);
        return (o == OP_UDIV) || (o == OP_SDIV);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared mul/div datapath: shift-add multiply or restoring divide.
// The divide path exists only when MULDIV_DIV_EN is defined.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int N = MULDIV_N
) (
    input  logic         div_mode,
    input  logic [N:0]   acc,
    input  logic [N-1:0] lo,
    input  logic [N-1:0] opnd,
    output logic [N:0]   acc_nxt,
    output logic [N-1:0] lo_nxt
);

    logic [N:0] sum;
`ifdef MULDIV_DIV_EN
    logic [N:0] shifted;
    logic [N:0] trial;
`else
    logic unused_div;
    assign unused_div = div_mode ^ acc[N];
`endif

    always_comb begin
        // Multiply: acc holds the upper product half, lo the multiplier shifting out.
        sum     = {1'b0, acc[N-1:0]} + {1'b0, (lo[0] ? opnd : {N{1'b0}})};
        acc_nxt = {1'b0, sum[N:1]};
        lo_nxt  = {sum[0], lo[N-1:1]};
`ifdef MULDIV_DIV_EN
        shifted = {acc[N-1:0], lo[N-1]};
        trial   = shifted - {1'b0, opnd};
        if (div_mode) begin
            // Divide: acc is the partial remainder, lo shifts dividend out and quotient in.
            acc_nxt = trial[N] ? shifted : trial;
            lo_nxt  = {lo[N-2:0], ~trial[N]};
        end
`endif
    end

endmodule

// File: rtl/muldiv_unit.sv
// Fixed-latency MUL/UMULH/UDIV/SDIV unit feeding the register-file write port.
// Define MULDIV_DIV_EN to compile in the divider; otherwise UDIV/SDIV return 0.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int N = MULDIV_N
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [4:0]   wa_in,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result,
    output logic [4:0]   wa3,
    output logic         we3
);

    localparam int CW = $clog2(N);

    state_t         state, state_nxt;
    op_t            op_q;
    logic [CW-1:0]  cnt;
    logic [N:0]     acc, acc_nxt;
    logic [N-1:0]   lo, lo_nxt, opnd;
    logic [N-1:0]   lo_init, opnd_init, res_nxt;
    logic           accept, last;
`ifdef MULDIV_DIV_EN
    logic           q_neg, div0;
    logic [N-1:0]   a_abs, b_abs;
`endif

    assign accept = start && (state == IDLE);
    assign last   = (state == RUN) && (cnt == CW'(N - 1));

    assign busy = (state != IDLE);
    assign done = (state == DONE);
    assign we3  = done && (wa3 != XZR_ADDR);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last)  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand routing at accept: multiply keeps the multiplier in lo, divide the dividend.
    always_comb begin
        lo_init   = b;
        opnd_init = a;
`ifdef MULDIV_DIV_EN
        a_abs = a[N-1] ? -a : a;
        b_abs = b[N-1] ? -b : b;
        if (op_t'(op) == OP_UDIV) begin
            lo_init   = a;
            opnd_init = b;
        end else if (op_t'(op) == OP_SDIV) begin
            lo_init   = a_abs;
            opnd_init = b_abs;
        end
`endif
    end

    muldiv_step #(.N(N)) u_step (
        .div_mode (is_div(op_q)),
        .acc      (acc),
        .lo       (lo),
        .opnd     (opnd),
        .acc_nxt  (acc_nxt),
        .lo_nxt   (lo_nxt)
    );

    always_comb begin
        res_nxt = '0;
        case (op_q)
            OP_MUL:   res_nxt = lo_nxt;
            OP_UMULH: res_nxt = acc_nxt[N-1:0];
`ifdef MULDIV_DIV_EN
            OP_UDIV:  res_nxt = div0 ? '0 : lo_nxt;
            OP_SDIV:  res_nxt = div0 ? '0 : (q_neg ? -lo_nxt : lo_nxt);
`endif
            default:  res_nxt = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_q   <= OP_MUL;
            wa3    <= '0;
            cnt    <= '0;
            acc    <= '0;
            lo     <= '0;
            opnd   <= '0;
            result <= '0;
`ifdef MULDIV_DIV_EN
            q_neg  <= 1'b0;
            div0   <= 1'b0;
`endif
        end else if (accept) begin
            op_q   <= op_t'(op);
            wa3    <= wa_in;
            cnt    <= '0;
            acc    <= '0;
            lo     <= lo_init;
            opnd   <= opnd_init;
`ifdef MULDIV_DIV_EN
            q_neg  <= a[N-1] ^ b[N-1];
            div0   <= (b == '0);
`endif
        end else if (state == RUN) begin
            acc <= acc_nxt;
            lo  <= lo_nxt;
            cnt <= cnt + 1'b1;
            if (last) result <= res_nxt;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases plus randomized ops vs. an arithmetic model.
module tb_muldiv_unit;

`ifdef MULDIV_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [1:0]  op;
    logic [63:0] a, b;
    logic [4:0]  wa_in;
    logic        busy, done, we3;
    logic [63:0] result;
    logic [4:0]  wa3;

    int n_chk = 0;
    int n_err = 0;

    muldiv_unit dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .wa_in   (wa_in),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .wa3     (wa3),
        .we3     (we3)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: plain 128-bit products and magnitude division with a sign fix-up.
    function automatic logic [63:0] ref_res(input logic [1:0] o, input logic [63:0] x, input logic [63:0] y);
        logic [127:0] p;
        logic [63:0]  mx, my, q;
        p  = {64'd0, x} * {64'd0, y};
        mx = x[63] ? (64'd0 - x) : x;
        my = y[63] ? (64'd0 - y) : y;
        case (o)
            2'd0: return p[63:0];
            2'd1: return p[127:64];
            2'd2: return (!DIV_EN || y == 0) ? 64'd0 : x / y;
            default: begin
                if (!DIV_EN || y == 0) return 64'd0;
                q = mx / my;
                return (x[63] ^ y[63]) ? (64'd0 - q) : q;
            end
        endcase
    endfunction

    task automatic do_op(input string tag, input logic [1:0] o, input logic [63:0] x,
                         input logic [63:0] y, input logic [4:0] w, input bit poke);
        int cyc;
        logic [63:0] exp;
        exp = ref_res(o, x, y);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y; wa_in = w;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        chk({tag, ":busy_c1"}, busy, 1);
        while (!done && cyc < 200) begin
            if (poke && cyc == 10) begin
                start = 1'b1; op = 2'd0; a = 64'd1234; b = 64'd99; wa_in = 5'd9;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        chk({tag, ":done_cyc"}, cyc, 65);
        chk({tag, ":result"}, result, exp);
        chk({tag, ":wa3"}, wa3, w);
        chk({tag, ":we3"}, we3, (w != 5'd31));
        chk({tag, ":busy_done"}, busy, 1);
        @(posedge clk); #1;
        chk({tag, ":done_clr"}, {busy, done, we3}, 3'b000);
        chk({tag, ":result_hold"}, result, exp);
    endtask

    logic [63:0] specials [6] = '{64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF,
                                  64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 64'd7};

    function automatic logic [63:0] rand_opnd();
        if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 5)];
        return {$urandom, $urandom} >> $urandom_range(0, 63);
    endfunction

    initial begin
        int seen;
        reset_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0; wa_in = '0;
        #23;
        chk("rst:outs", {busy, done, we3, wa3}, 8'd0);
        chk("rst:result", result, 0);
        @(negedge clk); reset_n = 1'b1;

        do_op("mul7x6",   2'd0, 64'd7, 64'd6, 5'd5, 1'b0);
        do_op("umulh",    2'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd1, 1'b0);
        do_op("udiv",     2'd2, 64'd100, 64'd7, 5'd2, 1'b0);
        do_op("sdiv",     2'd3, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd3, 1'b0);
        do_op("udiv0",    2'd2, 64'd5, 64'd0, 5'd4, 1'b0);
        do_op("sdiv0",    2'd3, 64'hFFFF_FFFF_FFFF_FFF9, 64'd0, 5'd4, 1'b0);
        do_op("sdivmin",  2'd3, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd6, 1'b0);
        do_op("ignore",   2'd1, 64'hDEAD_BEEF_0000_1111, 64'h1234_5678_9ABC_DEF0, 5'd7, 1'b1);
        do_op("xzr",      2'd0, 64'd11, 64'd13, 5'd31, 1'b0);

        // Abort mid-RUN with reset.
        @(negedge clk);
        start = 1'b1; op = 2'd0; a = 64'd5; b = 64'd5; wa_in = 5'd8;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (19) @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        chk("abort:outs", {busy, done, we3}, 3'b000);
        chk("abort:result", result, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        seen = 0;
        repeat (80) begin
            @(posedge clk); #1;
            if (done || we3) seen++;
        end
        chk("abort:no_done", seen, 0);
        do_op("mul3x3", 2'd0, 64'd3, 64'd3, 5'd10, 1'b0);

        for (int i = 0; i < 24; i++) begin
            do_op($sformatf("rnd%0d", i), 2'($urandom_range(0, 3)), rand_opnd(), rand_opnd(),
                  5'($urandom_range(0, 31)), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide execution unit for the LEGv8 datapath. It sits directly downstream of the register file: it consumes the two read-port operands (rd1, rd2) and produces a 64-bit result with a destination address and write enable, which drive the register file write port (wd3, wa3, we3). Supported operations are MUL, UMULH, UDIV and SDIV. Every operation has a fixed latency and follows a start/busy/done handshake.

## Interface
- N, 64, operand and result width in bits
- clk  in  1  clock; all state changes on the rising edge
- reset_n  in  1  reset, asynchronous, active-low
- start  in  1  request; sampled on the rising edge of clk, accepted only when busy=0
- op  in  2  operation: 00 MUL (low N bits), 01 UMULH (high N bits, unsigned), 10 UDIV, 11 SDIV
- a  in  N  operand 1 (from rd1); dividend or multiplicand
- b  in  N  operand 2 (from rd2); divisor or multiplier
- wa_in  in  5  destination register for the result
- busy  out  1  high from the cycle after accept through the DONE cycle
- done  out  1  one-cycle pulse; result is valid
- result  out  N  result; holds its value until the next done
- wa3  out  5  destination register, captured at accept
- we3  out  1  register-file write enable; equals done, except forced 0 when wa3=31 (XZR)

## Operation
- FSM states and transitions:
  - IDLE: go to RUN when start=1.
  - RUN: iteration counter counts 0..N-1. After the last iteration, go to DONE.
  - DONE: drive done=1, then go to IDLE.
- At accept, latch op, wa_in and the working operands.
- SDIV operand preparation at accept: take |a| and |b|, and record the sign of the quotient (sign(a) XOR sign(b)).
- MUL and UMULH: shift-add multiplication, one multiplier bit per RUN cycle, into a 2N-bit product.
  - MUL returns product[N-1:0].
  - UMULH returns product[2N-1:N].
- UDIV and SDIV: restoring division, one quotient bit per RUN cycle, with an (N+1)-bit partial remainder.
  - SDIV negates the quotient when the recorded quotient sign is 1 (two's complement).
- Special cases:
  - Divide by zero (b=0): result=0 for both UDIV and SDIV. Latency is unchanged.
  - SDIV of 0x8000_0000_0000_0000 by -1: result=0x8000_0000_0000_0000 (wraps).
  - All arithmetic is modulo 2^N; there is no overflow flag.
- start while busy=1 is ignored; no queueing.
- start on the cycle done=1 is ignored, because busy is still 1.
- The block never writes XZR: wa3=31 still produces the done pulse, but we3 stays 0.

## Timing
- Accept edge is cycle 0.
- busy=1 in cycles 1..N+1.
- done=1, we3=1 (when wa3≠31), and result valid in cycle N+1. For N=64 this is cycle 65.
- The earliest next accept edge is cycle N+2.
- Reset values (asynchronous, while reset_n=0): FSM=IDLE, busy=0, done=0, we3=0, result=0, wa3=0, counter=0.
- Reset asserted mid-RUN or in DONE aborts the operation immediately. No done and no we3 are produced for the aborted operation.
- The first rising edge after reset_n is released may accept a start.
- Outputs are registered. There is no combinational path from any input to busy, done, result, wa3 or we3.

## Configuration
- MULDIV_DIV_EN defined: the divider datapath is compiled in and all four ops behave as above.
- MULDIV_DIV_EN not defined: the divider is compiled out.
  - op 10 and op 11 are still accepted, with the same latency and handshake.
  - They return result=0.
  - we3 still follows done and the wa3≠31 rule.

## Structure
- Package muldiv_pkg contains:
  - op_t: enum of the four operations.
  - state_t: enum IDLE, RUN, DONE.
  - Constant XZR_ADDR = 5'd31.
  - Constant MULDIV_LAT = N+1.
- One sub-module, muldiv_step: combinational single-iteration datapath.
  - Multiply mode: conditional add and shift.
  - Divide mode: trial subtract, restore and quotient bit.
- Top-level muldiv_unit holds the FSM, the counter, the operand, product and remainder registers, and the sign fix-up.

## Test plan
- MUL, a=7, b=6, wa_in=5 → done at cycle 65, result=42, wa3=5, we3=1.
- UMULH, a=0xFFFF_FFFF_FFFF_FFFF, b=2 → result=1.
- UDIV, 100/7 → result=14.
- SDIV, -7/2 → result=0xFFFF_FFFF_FFFF_FFFD (-3).
- UDIV, 5/0 → result=0.
- SDIV, 0x8000_0000_0000_0000 / 0xFFFF_FFFF_FFFF_FFFF → result=0x8000_0000_0000_0000.
- With MULDIV_DIV_EN undefined, UDIV 100/7 → result=0, done still at cycle 65.
- start pulsed again at cycle 10 with different operands → ignored; first result unchanged. Then MUL with wa_in=31 → done=1, we3=0.
- reset_n low at cycle 20 of an operation → busy, done, we3 and result go to 0 immediately, and no done follows. After release, MUL 3×3 completes with result=9 at cycle 65.
